// File: rtl/axi_slave_data_mem.sv
// AXI4 slave backed by a word-addressed 32-bit RAM; INCR/FIXED bursts, one
// outstanding transaction per direction, independent read and write FSMs.
//
// state  | meaning
// W_IDLE | AWREADY high, waiting for a write address
// W_DATA | WREADY high, accepting beats until beat == len
// W_RESP | BVALID high, waiting for BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID high, presenting beats until the last is taken
module axi_slave_data_mem #(
   parameter int AXI_ADDR_W = 32,
   parameter int MEM_AW     = 10,
   parameter int ID_W       = 1
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic [ID_W-1:0]       S_AXI_AWID,
   input  logic [AXI_ADDR_W-1:0] S_AXI_AWADDR,
   input  logic [7:0]            S_AXI_AWLEN,
   input  logic [2:0]            S_AXI_AWSIZE,
   input  logic [1:0]            S_AXI_AWBURST,
   input  logic                  S_AXI_AWVALID,
   output logic                  S_AXI_AWREADY,
   input  logic [31:0]           S_AXI_WDATA,
   input  logic [3:0]            S_AXI_WSTRB,
   input  logic                  S_AXI_WLAST,
   input  logic                  S_AXI_WVALID,
   output logic                  S_AXI_WREADY,
   output logic [ID_W-1:0]       S_AXI_BID,
   output logic [1:0]            S_AXI_BRESP,
   output logic                  S_AXI_BVALID,
   input  logic                  S_AXI_BREADY,
   input  logic [ID_W-1:0]       S_AXI_ARID,
   input  logic [AXI_ADDR_W-1:0] S_AXI_ARADDR,
   input  logic [7:0]            S_AXI_ARLEN,
   input  logic [2:0]            S_AXI_ARSIZE,
   input  logic [1:0]            S_AXI_ARBURST,
   input  logic                  S_AXI_ARVALID,
   output logic                  S_AXI_ARREADY,
   output logic [ID_W-1:0]       S_AXI_RID,
   output logic [31:0]           S_AXI_RDATA,
   output logic [1:0]            S_AXI_RRESP,
   output logic                  S_AXI_RLAST,
   output logic                  S_AXI_RVALID,
   input  logic                  S_AXI_RREADY
);

   localparam logic [2:0] SIZE_WORD   = 3'b010;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   logic [31:0] mem [0:(2**MEM_AW)-1];

   w_state_t            w_state, w_next;
   logic                aw_ready, w_ready, b_valid;
   logic [1:0]          b_resp;
   logic [ID_W-1:0]     b_id;
   logic [MEM_AW-1:0]   w_idx;
   logic [7:0]          w_len, w_beat;
   logic                w_fixed, w_err;

   r_state_t            r_state, r_next;
   logic                ar_ready, r_valid, r_last;
   logic [1:0]          r_resp;
   logic [ID_W-1:0]     r_id;
   logic [31:0]         r_data;
   logic [MEM_AW-1:0]   r_idx;
   logic [7:0]          r_len, r_beat;
   logic                r_fixed, r_err;

   logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic                aw_unsup, ar_unsup;
   logic                w_last_beat, w_lmis, w_err_now, mem_we;
   logic                r_last_beat;
   logic [MEM_AW-1:0]   ld_idx;
   logic [31:0]         ld_word;
   logic                unused_ok;

   assign aw_hs = S_AXI_AWVALID && aw_ready;
   assign w_hs  = S_AXI_WVALID && w_ready;
   assign b_hs  = b_valid && S_AXI_BREADY;
   assign ar_hs = S_AXI_ARVALID && ar_ready;
   assign r_hs  = r_valid && S_AXI_RREADY;

   assign aw_unsup = (S_AXI_AWSIZE != SIZE_WORD) || S_AXI_AWBURST[1];
   assign ar_unsup = (S_AXI_ARSIZE != SIZE_WORD) || S_AXI_ARBURST[1];

   // A WLAST that disagrees with the beat count poisons this beat and the rest
   assign w_last_beat = (w_beat == w_len);
   assign w_lmis      = w_hs && (S_AXI_WLAST != w_last_beat);
   assign w_err_now   = w_err || w_lmis;
   assign mem_we      = w_hs && !w_err_now && !ARESET;

   assign r_last_beat = (r_beat == r_len);

   assign unused_ok = ^{S_AXI_AWADDR[AXI_ADDR_W-1:MEM_AW+2], S_AXI_AWADDR[1:0],
                        S_AXI_ARADDR[AXI_ADDR_W-1:MEM_AW+2], S_AXI_ARADDR[1:0]};

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs) w_next = W_DATA;
         W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
         W_RESP:  if (b_hs) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         w_state  <= W_IDLE;
         aw_ready <= 1'b0;
         w_ready  <= 1'b0;
         b_valid  <= 1'b0;
         b_resp   <= RESP_OKAY;
         b_id     <= '0;
         w_idx    <= '0;
         w_len    <= '0;
         w_beat   <= '0;
         w_fixed  <= 1'b0;
         w_err    <= 1'b0;
      end else begin
         w_state  <= w_next;
         aw_ready <= (w_next == W_IDLE);
         w_ready  <= (w_next == W_DATA);
         b_valid  <= (w_next == W_RESP);
         if (aw_hs) begin
            b_id    <= S_AXI_AWID;
            w_idx   <= S_AXI_AWADDR[MEM_AW+1:2];
            w_len   <= S_AXI_AWLEN;
            w_beat  <= '0;
            w_fixed <= (S_AXI_AWBURST == 2'b00);
            w_err   <= aw_unsup;
         end
         if (w_hs) begin
            w_beat <= w_beat + 8'd1;
            if (!w_fixed) w_idx <= w_idx + 1'b1;
            if (w_lmis) w_err <= 1'b1;
            if (w_last_beat) b_resp <= w_err_now ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (S_AXI_WSTRB[i]) mem[w_idx][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
         end
      end
   end

   // Word for the beat being launched; forwards a same-cycle write so the
   // next beat sees data committed on this edge.
   always_comb begin
      ld_idx = ar_hs ? S_AXI_ARADDR[MEM_AW+1:2] : (r_fixed ? r_idx : r_idx + 1'b1);
      ld_word = mem[ld_idx];
      if (mem_we && (w_idx == ld_idx)) begin
         for (int i = 0; i < 4; i++) begin
            if (S_AXI_WSTRB[i]) ld_word[8*i +: 8] = S_AXI_WDATA[8*i +: 8];
         end
      end
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_DATA;
         R_DATA:  if (r_hs && r_last_beat) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state  <= R_IDLE;
         ar_ready <= 1'b0;
         r_valid  <= 1'b0;
         r_last   <= 1'b0;
         r_resp   <= RESP_OKAY;
         r_id     <= '0;
         r_data   <= '0;
         r_idx    <= '0;
         r_len    <= '0;
         r_beat   <= '0;
         r_fixed  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= r_next;
         ar_ready <= (r_next == R_IDLE);
         if (ar_hs) begin
            r_id    <= S_AXI_ARID;
            r_idx   <= ld_idx;
            r_len   <= S_AXI_ARLEN;
            r_beat  <= '0;
            r_fixed <= (S_AXI_ARBURST == 2'b00);
            r_err   <= ar_unsup;
            r_valid <= 1'b1;
            r_last  <= (S_AXI_ARLEN == 8'd0);
            r_resp  <= ar_unsup ? RESP_SLVERR : RESP_OKAY;
            r_data  <= ar_unsup ? 32'd0 : ld_word;
         end else if (r_hs) begin
            if (r_last_beat) begin
               r_valid <= 1'b0;
               r_last  <= 1'b0;
            end else begin
               r_beat <= r_beat + 8'd1;
               r_idx  <= ld_idx;
               r_last <= ((r_beat + 8'd1) == r_len);
               r_data <= r_err ? 32'd0 : ld_word;
            end
         end
      end
   end

   assign S_AXI_AWREADY = aw_ready;
   assign S_AXI_WREADY  = w_ready;
   assign S_AXI_BVALID  = b_valid;
   assign S_AXI_BRESP   = b_resp;
   assign S_AXI_BID     = b_id;
   assign S_AXI_ARREADY = ar_ready;
   assign S_AXI_RVALID  = r_valid;
   assign S_AXI_RLAST   = r_last;
   assign S_AXI_RRESP   = r_resp;
   assign S_AXI_RID     = r_id;
   assign S_AXI_RDATA   = r_data;

endmodule

// File: tb/tb_axi_slave_data_mem.sv
// Directed bench for axi_slave_data_mem: single-beat vector table plus
// hand-written burst, stall, error and mid-burst reset sequences.
module tb_axi_slave_data_mem;

   localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
   localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
   localparam logic [2:0] SZ4 = 3'b010;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [0:0]  S_AXI_AWID, S_AXI_BID, S_AXI_ARID, S_AXI_RID;
   logic [31:0] S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_RDATA;
   logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN;
   logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE;
   logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
   logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
   logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

   axi_slave_data_mem #(.AXI_ADDR_W(32), .MEM_AW(10), .ID_W(1)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
      .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
      .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
   );

   always #5 ACLK = ~ACLK;

   int errors = 0;
   int checks = 0;
   logic [31:0] wbuf [0:15];
   logic [3:0]  sbuf [0:15];
   logic [31:0] rbuf [0:15];

   typedef struct {
      logic [31:0] wa;
      logic [31:0] wd;
      logic [3:0]  ws;
      logic [31:0] ra;
      logic [31:0] exp;
   } vec_t;
   vec_t vt [0:5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // early < 0: WLAST on the final beat; otherwise WLAST only on beat 'early'
   task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size,
                           input int early, output logic [1:0] resp, output int beats);
      int n;
      beats = 0;
      resp = 2'bxx;
      S_AXI_AWID = 1'b1; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
      S_AXI_AWBURST = burst; S_AXI_AWSIZE = size; S_AXI_AWVALID = 1'b1;
      n = 0;
      while (!S_AXI_AWREADY && n < 50) begin tick(); n++; end
      if (n >= 50) chk("awready_timeout", 32'd0, 32'd1);
      tick();
      S_AXI_AWVALID = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         S_AXI_WDATA = wbuf[b]; S_AXI_WSTRB = sbuf[b];
         S_AXI_WLAST = (early < 0) ? (b == int'(len)) : (b == early);
         S_AXI_WVALID = 1'b1;
         n = 0;
         while (!S_AXI_WREADY && n < 50) begin tick(); n++; end
         if (n >= 50) begin
            chk("wready_timeout", 32'd0, 32'd1);
            break;
         end
         tick();
         beats++;
      end
      S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
      chk("bvalid_latency", {31'd0, S_AXI_BVALID}, 32'd1);
      n = 0;
      while (!S_AXI_BVALID && n < 50) begin tick(); n++; end
      resp = S_AXI_BRESP;
      chk("bid", {31'd0, S_AXI_BID}, 32'd1);
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      chk("awready_after_b", {31'd0, S_AXI_AWREADY}, 32'd1);
   endtask

   // rpat bit k drives RREADY during the k-th cycle after the AR handshake
   task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size,
                          input logic [15:0] rpat, output logic [1:0] resp);
      int n, got, cyc;
      logic [31:0] pd;
      logic pl, stalled;
      resp = 2'bxx;
      S_AXI_ARID = 1'b1; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
      S_AXI_ARBURST = burst; S_AXI_ARSIZE = size; S_AXI_ARVALID = 1'b1;
      n = 0;
      while (!S_AXI_ARREADY && n < 50) begin tick(); n++; end
      if (n >= 50) chk("arready_timeout", 32'd0, 32'd1);
      tick();
      S_AXI_ARVALID = 1'b0;
      chk("rvalid_latency", {31'd0, S_AXI_RVALID}, 32'd1);
      chk("rid", {31'd0, S_AXI_RID}, 32'd1);
      got = 0; cyc = 0;
      while (got <= int'(len) && cyc < 200) begin
         S_AXI_RREADY = rpat[cyc % 16];
         stalled = 1'b0;
         pd = S_AXI_RDATA; pl = S_AXI_RLAST;
         if (S_AXI_RVALID && S_AXI_RREADY) begin
            rbuf[got] = S_AXI_RDATA;
            resp = S_AXI_RRESP;
            chk("rlast", {31'd0, S_AXI_RLAST}, {31'd0, got == int'(len)});
            got++;
         end else if (S_AXI_RVALID) begin
            stalled = 1'b1;
         end
         tick();
         if (stalled) begin
            chk("stall_rdata", S_AXI_RDATA, pd);
            chk("stall_rlast", {31'd0, S_AXI_RLAST}, {31'd0, pl});
         end
         cyc++;
      end
      S_AXI_RREADY = 1'b0;
      if (got != int'(len) + 1) chk("read_beats_timeout", got, int'(len) + 1);
      chk("arready_after_r", {31'd0, S_AXI_ARREADY}, 32'd1);
   endtask

   logic [1:0] resp;
   int beats;

   initial begin
      vt[0] = '{32'h10,   32'hAABBCCDD, 4'hF, 32'h10, 32'hAABBCCDD};
      vt[1] = '{32'h10,   32'h11223344, 4'h5, 32'h10, 32'hAA22CC44};
      vt[2] = '{32'h1082, 32'h5A5A1234, 4'hF, 32'h80, 32'h5A5A1234};
      vt[3] = '{32'h84,   32'h01020304, 4'hF, 32'h84, 32'h01020304};
      vt[4] = '{32'h84,   32'hFFFFFFFF, 4'h8, 32'h84, 32'hFF020304};
      vt[5] = '{32'h86,   32'h00000000, 4'h0, 32'h84, 32'hFF020304};

      ARESET = 1'b1;
      S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = SZ4;
      S_AXI_AWBURST = INCR; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b0;
      S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = SZ4;
      S_AXI_ARBURST = INCR; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
      repeat (3) tick();

      chk("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
      chk("rst_wready",  {31'd0, S_AXI_WREADY},  32'd0);
      chk("rst_bvalid",  {31'd0, S_AXI_BVALID},  32'd0);
      chk("rst_bresp",   {30'd0, S_AXI_BRESP},   32'd0);
      chk("rst_bid",     {31'd0, S_AXI_BID},     32'd0);
      chk("rst_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
      chk("rst_rvalid",  {31'd0, S_AXI_RVALID},  32'd0);
      chk("rst_rlast",   {31'd0, S_AXI_RLAST},   32'd0);
      chk("rst_rdata",   S_AXI_RDATA,            32'd0);
      chk("rst_rresp",   {30'd0, S_AXI_RRESP},   32'd0);
      chk("rst_rid",     {31'd0, S_AXI_RID},     32'd0);
      ARESET = 1'b0;
      tick();
      chk("awready_after_rst", {31'd0, S_AXI_AWREADY}, 32'd1);
      chk("arready_after_rst", {31'd0, S_AXI_ARREADY}, 32'd1);

      // four-beat INCR write then read-back
      wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
      for (int i = 0; i < 4; i++) sbuf[i] = 4'hF;
      do_write(32'h0, 8'd3, INCR, SZ4, -1, resp, beats);
      chk("incr_bresp", {30'd0, resp}, {30'd0, OKAY});
      do_read(32'h0, 8'd3, INCR, SZ4, 16'hFFFF, resp);
      chk("incr_rresp", {30'd0, resp}, {30'd0, OKAY});
      for (int i = 0; i < 4; i++) chk("incr_rdata", rbuf[i], 32'h11 * (i + 1));

      foreach (vt[k]) begin
         wbuf[0] = vt[k].wd; sbuf[0] = vt[k].ws;
         do_write(vt[k].wa, 8'd0, INCR, SZ4, -1, resp, beats);
         chk("vec_bresp", {30'd0, resp}, {30'd0, OKAY});
         do_read(vt[k].ra, 8'd0, INCR, SZ4, 16'hFFFF, resp);
         chk("vec_rdata", rbuf[0], vt[k].exp);
      end

      // INCR across the top of the array wraps to index 0
      wbuf[0] = 32'h1; wbuf[1] = 32'h2; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
      do_write(32'hFFC, 8'd1, INCR, SZ4, -1, resp, beats);
      chk("wrap_idx_bresp", {30'd0, resp}, {30'd0, OKAY});
      do_read(32'hFFC, 8'd0, INCR, SZ4, 16'hFFFF, resp);
      chk("wrap_idx_top", rbuf[0], 32'h1);
      do_read(32'h000, 8'd0, INCR, SZ4, 16'hFFFF, resp);
      chk("wrap_idx_zero", rbuf[0], 32'h2);

      // read stalls with RREADY 1,0,0,1,0,1,1...
      for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + i; sbuf[i] = 4'hF; end
      do_write(32'h40, 8'd3, INCR, SZ4, -1, resp, beats);
      do_read(32'h40, 8'd3, INCR, SZ4, 16'hFFE9, resp);
      for (int i = 0; i < 4; i++) chk("stall_beat", rbuf[i], 32'hA0 + i);

      // FIXED burst: last beat lands in the single word
      wbuf[0] = 32'h5; wbuf[1] = 32'h6; wbuf[2] = 32'h7;
      do_write(32'h100, 8'd2, FIXED, SZ4, -1, resp, beats);
      do_read(32'h100, 8'd1, FIXED, SZ4, 16'hFFFF, resp);
      chk("fixed_b0", rbuf[0], 32'h7);
      chk("fixed_b1", rbuf[1], 32'h7);

      // unsupported WRAP burst: consumed, SLVERR, memory untouched
      wbuf[0] = 32'h77; wbuf[1] = 32'h88;
      do_write(32'h200, 8'd1, INCR, SZ4, -1, resp, beats);
      wbuf[0] = 32'hDEAD0001; wbuf[1] = 32'hDEAD0002;
      do_write(32'h200, 8'd1, WRAP, SZ4, -1, resp, beats);
      chk("wrapburst_bresp", {30'd0, resp}, {30'd0, SLVERR});
      chk("wrapburst_beats", beats, 32'd2);
      do_read(32'h200, 8'd1, INCR, SZ4, 16'hFFFF, resp);
      chk("wrapburst_mem0", rbuf[0], 32'h77);
      chk("wrapburst_mem1", rbuf[1], 32'h88);
      do_read(32'h200, 8'd1, WRAP, SZ4, 16'hFFFF, resp);
      chk("rd_unsup_rresp", {30'd0, resp}, {30'd0, SLVERR});
      chk("rd_unsup_rdata", rbuf[0], 32'd0);

      // early WLAST on beat 0 of a three-beat burst
      do_write(32'h300, 8'd2, INCR, SZ4, 0, resp, beats);
      chk("early_wlast_bresp", {30'd0, resp}, {30'd0, SLVERR});
      chk("early_wlast_beats", beats, 32'd3);

      // reset after beat 1 of a four-beat write
      S_AXI_AWID = 1'b0; S_AXI_AWADDR = 32'h400; S_AXI_AWLEN = 8'd3;
      S_AXI_AWBURST = INCR; S_AXI_AWSIZE = SZ4; S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b1;
      S_AXI_WDATA = 32'hB0;
      tick();
      S_AXI_WDATA = 32'hB1;
      tick();
      S_AXI_WVALID = 1'b0;
      ARESET = 1'b1;
      tick();
      chk("midrst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
      chk("midrst_wready", {31'd0, S_AXI_WREADY}, 32'd0);
      ARESET = 1'b0;
      tick();
      chk("midrst_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
      chk("midrst_bvalid2", {31'd0, S_AXI_BVALID}, 32'd0);
      do_read(32'h400, 8'd1, INCR, SZ4, 16'hFFFF, resp);
      chk("midrst_kept0", rbuf[0], 32'hB0);
      chk("midrst_kept1", rbuf[1], 32'hB1);
      wbuf[0] = 32'hC0; sbuf[0] = 4'hF;
      do_write(32'h408, 8'd0, INCR, SZ4, -1, resp, beats);
      chk("midrst_new_bresp", {30'd0, resp}, {30'd0, OKAY});
      do_read(32'h408, 8'd0, INCR, SZ4, 16'hFFFF, resp);
      chk("midrst_new_data", rbuf[0], 32'hC0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/axi_slave_data_mem.md
# axi_slave_data_mem

AXI4 memory-mapped slave that terminates the data master's write/read test traffic on-chip. Sits directly downstream of the data master's M00_AXI port and replaces the verification slave so the master's write-then-read-back self-check runs in synthesized hardware. Implements a word-addressed 32-bit RAM with INCR/FIXED bursts and one outstanding transaction per direction.

## Interface
- AXI_ADDR_W, 32, byte address width of AW/AR channels
- MEM_AW, 10, word-index bits; depth = 2^MEM_AW words of 32 bits
- ID_W, 1, width of AWID/BID/ARID/RID
- Clock/reset: one clock; reset is synchronous and active-high.
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  synchronous active-high reset
- S_AXI_AWID / AWADDR / AWLEN / AWSIZE / AWBURST  in  ID_W / AXI_ADDR_W / 8 / 3 / 2  write address
- S_AXI_AWVALID in 1, S_AXI_AWREADY out 1  write address handshake
- S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WLAST in 1, S_AXI_WVALID in 1, S_AXI_WREADY out 1  write data
- S_AXI_BID out ID_W, S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1  write response
- S_AXI_ARID / ARADDR / ARLEN / ARSIZE / ARBURST  in  ID_W / AXI_ADDR_W / 8 / 3 / 2  read address
- S_AXI_ARVALID in 1, S_AXI_ARREADY out 1  read address handshake
- S_AXI_RID out ID_W, S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RLAST out 1, S_AXI_RVALID out 1, S_AXI_RREADY in 1  read data

## Operation
- Word index = addr[MEM_AW+1:2]; addr[1:0] and bits above MEM_AW+1 ignored (aliasing).
- Supported: SIZE=3'b010 with BURST=FIXED(00) or INCR(01). INCR index increments by 1 per beat, wraps modulo 2^MEM_AW. FIXED holds index.
- Unsupported (SIZE≠2 or BURST=WRAP/reserved): burst fully consumed, no memory writes, BRESP/RRESP=SLVERR(2'b10), RDATA=0.
- Write FSM: W_IDLE (AWREADY=1) → on AW handshake latch id/index/len/burst/err, beat count=0 → W_DATA (WREADY=1): each W handshake writes bytes per WSTRB (unless err); beat==len → W_RESP. W_RESP: BVALID=1, BID=latched id; on BREADY → W_IDLE.
- WLAST mismatch: if WLAST≠(beat==len) on any beat, set err flag → BRESP=SLVERR; burst still ends at beat len; beats already written stay written.
- Read FSM: R_IDLE (ARREADY=1) → on AR handshake latch id/index/len/burst/err → R_DATA: RVALID=1, RDATA=mem[index] captured at launch, RLAST=(beat==len). Each R handshake advances beat; on last → R_IDLE.
- Read and write FSMs independent; both may be active. Same-cycle write to a word already presented on RDATA does not alter that beat; later beats see new data.
- Memory contents not cleared by reset.

## Timing
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BRESP=0, BID=0, ARREADY=0, RVALID=0, RLAST=0, RDATA=0, RRESP=0, RID=0. AWREADY/ARREADY rise on first cycle after ARESET deasserts.
- AWREADY/ARREADY drop the cycle after handshake; WREADY high from cycle after AW handshake.
- Write: BVALID first cycle after last W handshake; AWREADY reasserts cycle after B handshake.
- Read latency: first RVALID cycle after AR handshake; back-to-back beats with RREADY=1 (one beat/cycle); RVALID/RDATA/RLAST/RRESP held stable while RREADY=0. ARREADY reasserts cycle after last R handshake.
- Valid outputs never deassert without handshake.
- ARESET mid-burst: both FSMs to idle next edge, outstanding responses dropped, partial writes retained.

## Test plan
- Reset then AW INCR addr 0x0 len 3, W 0x11,0x22,0x33,0x44 strb 0xF WLAST on beat 3 -> BVALID 1 cycle after beat 3, BRESP=OKAY; AR same -> RDATA 0x11..0x44, RLAST on 4th, first RVALID 1 cycle after AR.
- Write 0xAABBCCDD to 0x10 then WSTRB=0x5 data 0x11223344 -> readback 0xAA22CC44.
- INCR len 1 at index 2^MEM_AW−1 (addr 0xFFC, MEM_AW=10) data 0x1,0x2 -> read 0xFFC=0x1, 0x000=0x2.
- Read burst len 3 with RREADY toggling 1,0,0,1,... -> beats unchanged while stalled, no beat lost/duplicated, RLAST only on 4th.
- AWBURST=WRAP len 1 -> BRESP=SLVERR, memory unchanged; WLAST early on beat 0 of len 2 INCR -> BRESP=SLVERR, 3 beats accepted.
- ARESET for 1 cycle mid-write burst (after beat 1 of len 3) -> BVALID stays 0, AWREADY=1 cycle after reset release, new burst completes OKAY.
